odd_seq_checker: RTL and testbench

ODD_SEQ_CHECKER -- requirements
Module: odd_seq_checker

---
 rtl/odd_seq_checker.sv | 135 +++++++++++++
 tb/tb_odd_seq_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_seq_checker.sv
// Checks a stream of samples from an odd-value counter (1,3,5,..,MAX,1,..),
// acquires lock after LOCK_THRESH in-sequence samples and counts violations and wraps.
module odd_seq_checker #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LOCK_THRESH = 3,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_error,
    output logic [WIDTH-1:0] o_expected,
    output logic [ERR_W-1:0] o_err_count,
    output logic [15:0]      o_wrap_count
);

    typedef enum logic [1:0] {
        StUnlocked = 2'd0,
        StAcquire  = 2'd1,
        StLocked   = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] MaxVal  = '1;
    localparam logic [ERR_W-1:0] ErrMax  = '1;
    localparam logic [15:0]      WrapMax = '1;
    localparam logic [3:0]       Thresh  = 4'(LOCK_THRESH);
    localparam logic             SeedLocks = (LOCK_THRESH == 1);

    function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] x);
        return (x == MaxVal) ? WIDTH'(1) : x + WIDTH'(2);
    endfunction

    state_e     state_q;
    logic [3:0] match_q;

    logic             is_odd;
    logic             hit;
    logic [3:0]       match_inc;
    logic [WIDTH-1:0] nxt;
    logic             err_event;
    logic             wrap_event;

    always_comb begin
        is_odd     = i_count[0];
        hit        = (i_count == o_expected);
        match_inc  = match_q + 4'd1;
        nxt        = next_val(i_count);
        err_event  = i_valid && (state_q == StLocked) && !hit;
        wrap_event = i_valid && (state_q == StLocked) && hit && (i_count == WIDTH'(1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StUnlocked;
            match_q      <= 4'd0;
            o_locked     <= 1'b0;
            o_error      <= 1'b0;
            o_expected   <= WIDTH'(1);
            o_err_count  <= '0;
            o_wrap_count <= '0;
        end else begin
            o_error <= 1'b0;
            if (i_valid) begin
                unique case (state_q)
                    StUnlocked: begin
                        if (is_odd) begin
                            o_expected <= nxt;
                            match_q    <= 4'd1;
                            state_q    <= SeedLocks ? StLocked : StAcquire;
                            o_locked   <= SeedLocks;
                        end
                    end
                    StAcquire: begin
                        if (hit) begin
                            o_expected <= nxt;
                            match_q    <= match_inc;
                            if (match_inc >= Thresh) begin
                                state_q  <= StLocked;
                                o_locked <= 1'b1;
                            end
                        end else if (is_odd) begin
                            o_expected <= nxt;
                            match_q    <= 4'd1;
                            state_q    <= SeedLocks ? StLocked : StAcquire;
                            o_locked   <= SeedLocks;
                        end else begin
                            match_q  <= 4'd0;
                            state_q  <= StUnlocked;
                            o_locked <= 1'b0;
                        end
                    end
                    StLocked: begin
                        if (hit) begin
                            o_expected <= nxt;
                        end else begin
                            o_error <= 1'b1;
                            if (is_odd) begin
                                o_expected <= nxt;
                                match_q    <= 4'd1;
                                state_q    <= SeedLocks ? StLocked : StAcquire;
                                o_locked   <= SeedLocks;
                            end else begin
                                match_q  <= 4'd0;
                                state_q  <= StUnlocked;
                                o_locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        match_q  <= 4'd0;
                        state_q  <= StUnlocked;
                        o_locked <= 1'b0;
                    end
                endcase
            end

            // A clear coinciding with an event leaves that event counted.
            if (i_clear) begin
                o_err_count <= err_event ? ERR_W'(1) : '0;
            end else if (err_event && (o_err_count != ErrMax)) begin
                o_err_count <= o_err_count + ERR_W'(1);
            end

            if (i_clear) begin
                o_wrap_count <= wrap_event ? 16'd1 : 16'd0;
            end else if (wrap_event && (o_wrap_count != WrapMax)) begin
                o_wrap_count <= o_wrap_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_odd_seq_checker.sv
// Scoreboard bench for odd_seq_checker: two instances (default params, and
// LOCK_THRESH=1 / ERR_W=2) share stimulus and are compared against a behavioural model.
module tb_odd_seq_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       clear;
    logic [7:0] count;

    logic        locked_a, error_a;
    logic [7:0]  exp_a, err_a;
    logic [15:0] wrap_a;
    logic        locked_b, error_b;
    logic [7:0]  exp_b;
    logic [1:0]  err_b;
    logic [15:0] wrap_b;

    always #5 clk = ~clk;

    odd_seq_checker #(.WIDTH(8), .LOCK_THRESH(3), .ERR_W(8)) u_dut_a (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_count     (count),
        .i_clear     (clear),
        .o_locked    (locked_a),
        .o_error     (error_a),
        .o_expected  (exp_a),
        .o_err_count (err_a),
        .o_wrap_count(wrap_a)
    );

    odd_seq_checker #(.WIDTH(8), .LOCK_THRESH(1), .ERR_W(2)) u_dut_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_count     (count),
        .i_clear     (clear),
        .o_locked    (locked_b),
        .o_error     (error_b),
        .o_expected  (exp_b),
        .o_err_count (err_b),
        .o_wrap_count(wrap_b)
    );

    typedef struct {
        int         st;    // 0 unlocked, 1 acquire, 2 locked
        logic [7:0] expv;
        int         match;
        int         err;
        int         wrap;
        logic       error;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } sb_t;

    sb_t  sb_q[$];
    mdl_t ma, mb;
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [7:0] nxt(input logic [7:0] x);
        return (x == 8'd255) ? 8'd1 : 8'(x + 8'd2);
    endfunction

    function automatic mdl_t step(input mdl_t s, input bit r, input bit v, input logic [7:0] c,
                                  input bit cl, input int thresh, input int errmax);
        mdl_t n = s;
        bit ev_err = 0;
        bit ev_wrap = 0;
        bit do_seed = 0;
        bit do_unlock = 0;
        n.error = 1'b0;
        if (r) begin
            n.st = 0; n.expv = 8'd1; n.match = 0; n.err = 0; n.wrap = 0;
            return n;
        end
        if (v) begin
            case (s.st)
                0: do_seed = c[0];
                1: begin
                    if (c == s.expv) begin
                        n.match = s.match + 1;
                        n.expv  = nxt(c);
                        if (n.match >= thresh) n.st = 2;
                    end else if (c[0]) do_seed = 1;
                    else do_unlock = 1;
                end
                default: begin
                    if (c == s.expv) begin
                        n.expv = nxt(c);
                        ev_wrap = (c == 8'd1);
                    end else begin
                        n.error = 1'b1;
                        ev_err = 1;
                        if (c[0]) do_seed = 1;
                        else do_unlock = 1;
                    end
                end
            endcase
        end
        if (do_seed) begin
            n.expv = nxt(c); n.match = 1; n.st = (thresh == 1) ? 2 : 1;
        end
        if (do_unlock) begin
            n.st = 0; n.match = 0;
        end
        if (cl) n.err = ev_err ? 1 : 0;
        else if (ev_err && s.err < errmax) n.err = s.err + 1;
        if (cl) n.wrap = ev_wrap ? 1 : 0;
        else if (ev_wrap && s.wrap < 65535) n.wrap = s.wrap + 1;
        return n;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, expv);
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare the DUT outputs after the edge.
    task automatic drive(input bit r, input bit v, input logic [7:0] c, input bit cl);
        sb_t e;
        rst = r; valid = v; count = c; clear = cl;
        ma = step(ma, r, v, c, cl, 3, 255);
        mb = step(mb, r, v, c, cl, 1, 3);
        sb_q.push_back('{a: ma, b: mb});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("a_locked", {31'd0, locked_a}, {31'd0, e.a.st == 2});
        check_val("a_error",  {31'd0, error_a},  {31'd0, e.a.error});
        check_val("a_expect", {24'd0, exp_a},    {24'd0, e.a.expv});
        check_val("a_errcnt", {24'd0, err_a},    32'(e.a.err));
        check_val("a_wrap",   {16'd0, wrap_a},   32'(e.a.wrap));
        check_val("b_locked", {31'd0, locked_b}, {31'd0, e.b.st == 2});
        check_val("b_error",  {31'd0, error_b},  {31'd0, e.b.error});
        check_val("b_expect", {24'd0, exp_b},    {24'd0, e.b.expv});
        check_val("b_errcnt", {30'd0, err_b},    32'(e.b.err));
        check_val("b_wrap",   {16'd0, wrap_b},   32'(e.b.wrap));
        rst = 0; valid = 0; clear = 0;
    endtask

    initial begin
        rst = 1; valid = 0; clear = 0; count = 8'd0;
        ma = '{st: 0, expv: 8'd0, match: 0, err: 0, wrap: 0, error: 1'b0};
        mb = ma;
        #1;
        // Reset overrides valid and clear.
        drive(1, 1, 8'd1, 1);
        drive(1, 1, 8'd3, 0);
        check_val("rst_expect", {24'd0, exp_a}, 32'd1);
        check_val("rst_locked", {31'd0, locked_a}, 32'd0);

        // Lock acquisition on 1,3,5,7,9.
        drive(0, 1, 8'd1, 0);
        drive(0, 1, 8'd3, 0);
        check_val("acq_not_locked", {31'd0, locked_a}, 32'd0);
        drive(0, 1, 8'd5, 0);
        check_val("lock_after_5", {31'd0, locked_a}, 32'd1);
        drive(0, 1, 8'd7, 0);
        drive(0, 1, 8'd9, 0);
        check_val("expect_11", {24'd0, exp_a}, 32'd11);

        // Idle cycles keep lock.
        repeat (3) drive(0, 0, 8'd2, 0);
        check_val("idle_locked", {31'd0, locked_a}, 32'd1);
        drive(0, 1, 8'd11, 0);
        drive(0, 1, 8'd13, 0);
        drive(0, 1, 8'd15, 0);
        check_val("expect_17", {24'd0, exp_a}, 32'd17);

        // Run up to the wrap.
        for (int v = 17; v <= 255; v += 2) drive(0, 1, 8'(v), 0);
        drive(0, 1, 8'd1, 0);
        drive(0, 1, 8'd3, 0);
        check_val("wrap_count_1", {16'd0, wrap_a}, 32'd1);
        check_val("wrap_expect_5", {24'd0, exp_a}, 32'd5);

        // Even violation at expected 21, then re-seed at 27.
        for (int v = 5; v <= 19; v += 2) drive(0, 1, 8'(v), 0);
        drive(0, 1, 8'd24, 0);
        check_val("viol_error", {31'd0, error_a}, 32'd1);
        check_val("viol_unlocked", {31'd0, locked_a}, 32'd0);
        drive(0, 1, 8'd27, 0);
        check_val("viol_pulse_once", {31'd0, error_a}, 32'd0);
        drive(0, 1, 8'd29, 0);
        drive(0, 1, 8'd31, 0);
        check_val("relock_31", {31'd0, locked_a}, 32'd1);
        check_val("errcnt_1", {24'd0, err_a}, 32'd1);

        // Clear with a simultaneous violation, then clear alone.
        drive(0, 1, 8'd33, 0);
        drive(0, 1, 8'd38, 0);
        drive(0, 1, 8'd41, 0);
        drive(0, 1, 8'd43, 0);
        drive(0, 1, 8'd45, 0);
        drive(0, 1, 8'd50, 1);
        check_val("clear_evt_1", {24'd0, err_a}, 32'd1);
        drive(0, 1, 8'd51, 0);
        drive(0, 1, 8'd53, 0);
        drive(0, 1, 8'd55, 0);
        drive(0, 0, 8'd0, 1);
        check_val("clear_alone_0", {24'd0, err_a}, 32'd0);
        check_val("clear_keeps_lock", {31'd0, locked_a}, 32'd1);

        // Odd mismatch while locked re-seeds; acquire-state mismatches.
        drive(0, 1, 8'd91, 0);
        drive(0, 1, 8'd0, 0);
        drive(0, 1, 8'd7, 0);
        drive(0, 1, 8'd9, 0);
        drive(0, 1, 8'd4, 0);
        drive(0, 1, 8'd7, 0);
        drive(0, 1, 8'd11, 0);
        drive(0, 1, 8'd13, 0);
        drive(0, 1, 8'd15, 0);
        check_val("reseed_locked", {31'd0, locked_a}, 32'd1);

        // Five locked-state violations with re-lock between; narrow counter saturates.
        drive(0, 0, 8'd0, 1);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 8'd100, 0);
            drive(0, 1, 8'd101, 0);
            drive(0, 1, 8'd103, 0);
            drive(0, 1, 8'd105, 0);
        end
        check_val("sat_errcnt_b", {30'd0, err_b}, 32'd3);
        check_val("errcnt_a_5", {24'd0, err_a}, 32'd5);

        // Reset while locked with a mismatching sample: no error pulse.
        drive(1, 1, 8'd2, 0);
        check_val("rst_no_error", {31'd0, error_a}, 32'd0);
        check_val("rst_drop_lock", {31'd0, locked_b}, 32'd0);
        check_val("rst_err_b", {30'd0, err_b}, 32'd0);
        drive(0, 0, 8'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
